// File: rtl/fetch_branch_predictor.sv
// Fetch-stage pre-decoder: classifies jal/jalr/bxx and predicts the next fetch
// target from a 2-bit counter table, a return address stack or the immediate.
module fetch_branch_predictor #(
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4,
    parameter bit BHT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fet_valid,
    input  logic [31:0] fet_pc,
    input  logic [31:0] fet_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs1_val,
    input  logic        rs1_busy,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        is_jal,
    output logic        is_jalr,
    output logic        is_bxx,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pred_from_ras,
    output logic        jalr_stall
);

    localparam int IW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0] RAS_FULL = (PW+1)'(RAS_DEPTH);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        link_rd;
    logic        link_rs1;
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] i_imm;
    logic [31:0] jal_tgt;
    logic [31:0] bxx_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] push_val;
    logic        dir;

    assign opcode = fet_instr[6:0];
    assign rd     = fet_instr[11:7];
    assign rs1    = fet_instr[19:15];

    assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
    assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

    assign j_imm = {{12{fet_instr[31]}}, fet_instr[19:12], fet_instr[20],
                    fet_instr[30:21], 1'b0};
    assign b_imm = {{20{fet_instr[31]}}, fet_instr[7], fet_instr[30:25],
                    fet_instr[11:8], 1'b0};
    assign i_imm = {{21{fet_instr[31]}}, fet_instr[30:20]};

    assign is_jal  = fet_valid && (opcode == 7'b1101111);
    assign is_jalr = fet_valid && (opcode == 7'b1100111);
    assign is_bxx  = fet_valid && (opcode == 7'b1100011);

    // Return address stack: ptr_q is the next free slot, top is ptr_q-1
    logic [31:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW:0]   cnt_q;
    logic [PW-1:0] top_idx;
    logic          ras_push;
    logic          ras_pop;
    logic          ras_empty;
    logic          ras_upd;

    assign top_idx   = ptr_q - 1'b1;
    assign ras_empty = (cnt_q == '0);
    assign ras_push  = (is_jal || is_jalr) && link_rd;
    assign ras_pop   = is_jalr && link_rs1 && (!link_rd || (rd != rs1));

    assign pred_from_ras = ras_pop && !ras_empty;
    assign jalr_stall    = is_jalr && !pred_from_ras && (rs1 != 5'd0) && rs1_busy;
    assign ras_upd       = fet_valid && !stall && !flush && !jalr_stall;

    assign push_val = fet_pc + 32'd4;
    assign jal_tgt  = fet_pc + j_imm;
    assign bxx_tgt  = fet_pc + b_imm;
    assign jalr_tgt = pred_from_ras ? ras_q[top_idx]
                                    : ((rs1_val + i_imm) & 32'hFFFF_FFFE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (ras_upd) begin
            if (ras_pop && !ras_empty && ras_push) begin
                ras_q[top_idx] <= push_val;
            end else if (ras_pop && !ras_empty) begin
                ptr_q <= ptr_q - 1'b1;
                cnt_q <= cnt_q - 1'b1;
            end else if (ras_push) begin
                ras_q[ptr_q] <= push_val;
                ptr_q        <= ptr_q + 1'b1;
                if (cnt_q != RAS_FULL) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    if (BHT_EN) begin : g_bht
        logic [1:0]    ctr_q [BHT_DEPTH];
        logic [IW-1:0] rd_idx;
        logic [IW-1:0] wr_idx;
        logic          unused_upd_bits;

        assign rd_idx = fet_pc[IW+1:2];
        assign wr_idx = upd_pc[IW+1:2];
        assign dir    = ctr_q[rd_idx][1];
        assign unused_upd_bits = ^{upd_pc[31:IW+2], upd_pc[1:0]};

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < BHT_DEPTH; i++) begin
                    ctr_q[i] <= 2'b01;
                end
            end else if (upd_valid) begin
                if (upd_taken && (ctr_q[wr_idx] != 2'b11)) begin
                    ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'b01;
                end else if (!upd_taken && (ctr_q[wr_idx] != 2'b00)) begin
                    ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'b01;
                end
            end
        end
    end else begin : g_static
        logic unused_upd_bits;

        // Backward branches (negative offset) are predicted taken
        assign dir = fet_instr[31];
        assign unused_upd_bits = ^{upd_valid, upd_pc, upd_taken};
    end

    assign pred_taken = is_jal || (is_jalr && !jalr_stall) || (is_bxx && dir);

    always_comb begin
        pred_target = '0;
        unique case (1'b1)
            is_jal:  pred_target = jal_tgt;
            is_jalr: pred_target = jalr_tgt;
            is_bxx:  pred_target = bxx_tgt;
            default: pred_target = '0;
        endcase
    end

endmodule
